// File: rtl/zcull_depth_test.sv
// Generic in-order FIFO with occupancy count; storage is not reset, only pointers and count.
// Latency: a push is visible on pop_dat/pop_vld the cycle after it is written.
// Backpressure: pop only when pop_vld && pop_rdy; the pusher guarantees it never pushes when full.
module zcull_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_vld,
    input  logic [WIDTH-1:0]    push_dat,
    output logic                pop_vld,
    input  logic                pop_rdy,
    output logic [WIDTH-1:0]    pop_dat,
    output logic [CNT_BITS-1:0] count
);
    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                pop;

    assign pop_vld = (count != '0);
    assign pop     = pop_vld && pop_rdy;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop)      count <= count + 1'b1;
            else if (pop && !push_vld) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end
endmodule

// Z-cull depth test: keeps fragments that hit an empty pixel or are strictly closer, writes them back, forwards them out.
// Latency: accept in t, compare and z-buffer write in t+1, out_valid in t+2; each clear sweep takes 2**NUM_ADDR_BITS cycles.
// Backpressure: in_ready is a credit on output FIFO space counting the fragment in flight; held low while draining or clearing.
module zcull_depth_test #(
    parameter int Z_BITS        = 8,
    parameter int COLOR_BITS    = 8,
    parameter int NUM_ADDR_BITS = 7,
    parameter int OUT_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_clear,
    output logic                             clear_busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_ADDR_BITS-1:0]         in_addr,
    input  logic [Z_BITS-1:0]                in_z,
    input  logic [COLOR_BITS-1:0]            in_color,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_ADDR_BITS-1:0]         out_addr,
    output logic [COLOR_BITS-1:0]            out_color,
    output logic                             zb_wea,
    output logic [NUM_ADDR_BITS-1:0]         zb_addra,
    output logic [Z_BITS+COLOR_BITS:0]       zb_dina,
    output logic [NUM_ADDR_BITS-1:0]         zb_addrb,
    input  logic [Z_BITS+COLOR_BITS:0]       zb_doutb,
    output logic [31:0]                      drop_count
);
    localparam int PAYLOAD_BITS = Z_BITS + COLOR_BITS;
    localparam int CW           = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW:0] OUT_LIMIT = (CW + 1)'(OUT_DEPTH);

    typedef struct packed {
        logic                  vld;
        logic [COLOR_BITS-1:0] color;
        logic [Z_BITS-1:0]     z;
    } zword_t;

    typedef struct packed {
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [COLOR_BITS-1:0]    color;
    } frag_out_t;

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [NUM_ADDR_BITS-1:0] clear_addr;

    logic                     s1_valid;
    logic [NUM_ADDR_BITS-1:0] s1_addr;
    logic [Z_BITS-1:0]        s1_z;
    logic [COLOR_BITS-1:0]    s1_color;

    logic                     fwd_valid;
    logic [NUM_ADDR_BITS-1:0] fwd_addr;
    logic [Z_BITS-1:0]        fwd_z;
    logic [COLOR_BITS-1:0]    fwd_color;

    zword_t                   stored;
    logic                     keep;
    logic                     drop;
    logic                     accept;
    logic [CW-1:0]            fifo_count;
    logic [CW:0]              credit_used;
    frag_out_t                push_frag;
    frag_out_t                head_frag;

    assign accept      = in_valid && in_ready;
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
    assign in_ready    = (state == RUN) && (credit_used < OUT_LIMIT);
    assign clear_busy  = (state != RUN);
    assign zb_addrb    = accept ? in_addr : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            clear_addr <= '0;
        end else begin
            state      <= state_nxt;
            clear_addr <= (state == CLEAR) ? clear_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clear_addr == '1) state_nxt = RUN;
            RUN:     if (frame_clear)      state_nxt = DRAIN;
            DRAIN:   if (!s1_valid)        state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_z     <= '0;
            s1_color <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= in_addr;
                s1_z     <= in_z;
                s1_color <= in_color;
            end
        end
    end

    // The RAM read issued alongside last cycle's write returns stale data; the forward register covers it.
    always_comb begin
        stored = zb_doutb;
        if (fwd_valid && (fwd_addr == s1_addr)) begin
            stored = {1'b1, fwd_color, fwd_z};
        end
    end

    assign keep = s1_valid && (!stored.vld || (s1_z < stored.z));
    assign drop = s1_valid && !keep;

    always_comb begin
        zb_wea   = 1'b0;
        zb_addra = '0;
        zb_dina  = '0;
        if (state == CLEAR) begin
            zb_wea   = reset;
            zb_addra = clear_addr;
        end else if (keep) begin
            zb_wea   = 1'b1;
            zb_addra = s1_addr;
            zb_dina  = {1'b1, s1_color, s1_z};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_z     <= '0;
            fwd_color <= '0;
        end else if (state == CLEAR) begin
            fwd_valid <= 1'b0;
        end else if (keep) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= s1_addr;
            fwd_z     <= s1_z;
            fwd_color <= s1_color;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_count <= '0;
        else if (drop) drop_count <= drop_count + 32'd1;
    end

    assign push_frag = '{addr: s1_addr, color: s1_color};

    zcull_fifo #(
        .WIDTH    (NUM_ADDR_BITS + COLOR_BITS),
        .DEPTH    (OUT_DEPTH),
        .CNT_BITS (CW)
    ) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (keep),
        .push_dat (push_frag),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_frag),
        .count    (fifo_count)
    );

    assign out_addr  = head_frag.addr;
    assign out_color = head_frag.color;

    logic unused_ok;
    assign unused_ok = (PAYLOAD_BITS > 0);
endmodule

// File: tb/tb_zcull_depth_test.sv
// Bench for zcull_depth_test: directed scenarios plus a random stream against a per-pixel depth model.
module tb_zcull_depth_test;
    localparam int AB = 7, DEPTH = 128, WB = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_clear = 1'b0;
    logic          clear_busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AB-1:0] in_addr = '0;
    logic [7:0]    in_z = '0;
    logic [7:0]    in_color = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AB-1:0] out_addr;
    logic [7:0]    out_color;
    logic          zb_wea;
    logic [AB-1:0] zb_addra;
    logic [WB-1:0] zb_dina;
    logic [AB-1:0] zb_addrb;
    logic [WB-1:0] zb_doutb;
    logic [31:0]   drop_count;

    zcull_depth_test dut (
        .clk(clk), .reset(reset), .frame_clear(frame_clear), .clear_busy(clear_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_z(in_z), .in_color(in_color),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_color(out_color),
        .zb_wea(zb_wea), .zb_addra(zb_addra), .zb_dina(zb_dina), .zb_addrb(zb_addrb),
        .zb_doutb(zb_doutb), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // z-buffer RAM: write port A, registered read port B, read-before-write on collision
    logic [WB-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (zb_wea) ram[zb_addra] <= zb_dina;
        zb_doutb <= ram[zb_addrb];
    end

    // reference model: per-pixel stored depth, applied in acceptance order
    bit          mdl_vld [DEPTH];
    logic [7:0]  mdl_z   [DEPTH];
    logic [7:0]  mdl_c   [DEPTH];
    logic [14:0] exp_q [$];
    int          n_drop = 0, n_keep = 0, n_pop = 0;
    int          checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_accept(input logic [AB-1:0] a, input logic [7:0] z, input logic [7:0] c);
        if (!mdl_vld[a] || z < mdl_z[a]) begin
            mdl_vld[a] = 1'b1;
            mdl_z[a]   = z;
            mdl_c[a]   = c;
            exp_q.push_back({a, c});
            n_keep++;
        end else begin
            n_drop++;
        end
    endfunction

    function automatic void mdl_clear();
        foreach (mdl_vld[i]) mdl_vld[i] = 1'b0;
    endfunction

    // called at a negedge with this cycle's inputs applied; advances to the next negedge
    task automatic tick();
        logic [14:0] e;
        if (in_valid && in_ready) mdl_accept(in_addr, in_z, in_color);
        if (frame_clear && !clear_busy) mdl_clear();
        if (out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_addr", out_addr, e[14:8]);
                chk("pop_color", out_color, e[7:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [AB-1:0] a, input logic [7:0] z, input logic [7:0] c);
        int guard = 0;
        in_valid = 1'b1; in_addr = a; in_z = z; in_color = c;
        while (!in_ready && guard < 400) begin
            tick();
            guard++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_clear_busy"}, clear_busy, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_zb_wea"}, zb_wea, 0);
        chk({tag, "_zb_addra"}, zb_addra, 0);
        chk({tag, "_zb_dina"}, zb_dina, 0);
        chk({tag, "_zb_addrb"}, zb_addrb, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
    endtask

    // entered just after reset release; cycle k (1..DEPTH) must write address k-1 with zero
    task automatic clear_sweep(input string tag);
        int good = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (zb_wea === 1'b1 && zb_addra === 7'(k) && zb_dina === '0 && in_ready === 1'b0 && clear_busy === 1'b1)
                good++;
            @(negedge clk);
        end
        chk({tag, "_clear_writes"}, good, DEPTH);
        chk({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, p0, bad, wr_cnt, guard;
        logic [31:0] d0;
        logic [WB-1:0] exp_w;

        foreach (ram[i]) ram[i] = WB'($urandom);
        mdl_clear();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset_values("rst");
        reset = 1'b1;
        #1;
        clear_sweep("init");

        // first keep: write word and output two cycles after accept
        send(7'd5, 8'd40, 8'hAA);
        chk("keep1_wea", zb_wea, 1);
        chk("keep1_addra", zb_addra, 5);
        chk("keep1_dina", zb_dina, {1'b1, 8'hAA, 8'd40});
        tick();
        chk("keep1_out_valid", out_valid, 1);
        chk("keep1_out_addr", out_addr, 5);
        chk("keep1_out_color", out_color, 8'hAA);

        send(7'd5, 8'd50, 8'hBB); idle(3);
        chk("drop_farther", drop_count, 1);
        send(7'd5, 8'd40, 8'hCC); idle(3);
        chk("drop_equal", drop_count, 2);
        send(7'd5, 8'd10, 8'hDD); idle(3);
        chk("keep_closer_drops", drop_count, 2);
        chk("keep_closer_ram", ram[5], {1'b1, 8'hDD, 8'd10});

        // back-to-back same pixel exercises forwarding
        send(7'd9, 8'd30, 8'h31);
        send(7'd9, 8'd20, 8'h32);
        send(7'd9, 8'd25, 8'h33);
        idle(3);
        chk("b2b_ram9", ram[9], {1'b1, 8'h32, 8'd20});
        chk("b2b_drops", drop_count, 3);

        // output stall: credit stops at four in flight
        out_ready = 1'b0; n_acc = 0; p0 = n_pop;
        for (int c = 0; c < 10; c++) begin
            in_valid = (n_acc < 6); in_addr = 7'(20 + n_acc); in_z = 8'd1; in_color = 8'(8'h60 + n_acc);
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        chk("bp_accepted", n_acc, 4);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            in_valid = (n_acc < 6); in_addr = 7'(20 + n_acc); in_z = 8'd1; in_color = 8'(8'h60 + n_acc);
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_resume_accepted", n_acc, 6);
        chk("bp_pops", n_pop - p0, 6);

        // frame clear with a fragment in the compare stage
        send(7'd30, 8'd9, 8'h44);
        chk("fc_s1_write", {zb_wea, zb_addra}, {1'b1, 7'd30});
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
        chk("fc_busy", clear_busy, 1);
        chk("fc_in_ready", in_ready, 0);
        wr_cnt = 0; guard = 0;
        while (!in_ready && guard < 400) begin
            if (zb_wea && zb_dina == '0) wr_cnt++;
            tick();
            guard++;
        end
        chk("fc_clear_writes", wr_cnt, DEPTH);
        d0 = drop_count;
        send(7'd5, 8'd200, 8'h5C); idle(3);
        chk("fc_keep_after_clear", ram[5], {1'b1, 8'h5C, 8'd200});
        chk("fc_no_drop", drop_count, d0);

        // random stream with collisions, stalls and occasional clears
        for (int i = 0; i < 800; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            in_addr     = 7'($urandom_range(0, 15));
            in_z        = 8'($urandom_range(0, 63));
            in_color    = 8'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            frame_clear = ($urandom_range(0, 299) == 0);
            tick();
        end
        in_valid = 1'b0; frame_clear = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((clear_busy || exp_q.size() != 0) && guard < 400) begin
            tick();
            guard++;
        end
        idle(5);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_drop_count", drop_count, n_drop);
        chk("rand_pops", n_pop, n_keep);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_w = mdl_vld[a] ? {1'b1, mdl_c[a], mdl_z[a]} : '0;
            if (ram[a] !== exp_w) bad++;
        end
        chk("rand_ram_image", bad, 0);

        // reset in the middle of a stalled stream
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_addr = 7'($urandom_range(40, 50)); in_z = 8'($urandom); in_color = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        #1;
        reset_values("midrst");
        exp_q.delete(); mdl_clear(); n_drop = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        clear_sweep("rerst");
        send(7'd3, 8'd7, 8'h3C); idle(3);
        chk("rerst_keep_ram", ram[3], {1'b1, 8'h3C, 8'd7});
        chk("rerst_drops", drop_count, 0);
        chk("rerst_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
